multicycle_decoder: RTL and testbench
=====================================

# multicycle_decoder

Multicycle control unit for the ARM datapath. Each instruction runs over 2–5 clock cycles and shares one ALU and one memory port. A Moore state machine sequences fetch, decode, execute, memory and write-back. A parametrised ALU decoder extends the base ADD/SUB/AND/ORR set with EOR, MOV, CMP and TST. The block sits between the instruction register (Op, Funct, Rd fields) and the condition-check logic (CondEx). It drives every datapath mux select and write enable.

## Interface
- EXT_OPS, 1: enables EOR/MOV/CMP/TST; 0 restricts to ADD/SUB/AND/ORR.
- ALUCTRL_W, 3: ALUControl width. Must be ≥3 when EXT_OPS=1 and ≥2 otherwise.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- Op  in  2  instruction [27:26].
- Funct  in  6  instruction [25:20]: I, cmd[3:0], S/L.
- Rd  in  4  destination register.
- CondEx  in  1  condition passed, valid from DECODE onward.
- PCWrite, IRWrite, RegW, MemW  out  1 each  write enables.
- AdrSrc, ALUSrcA  out  1 each  mux selects.
- ResultSrc, ALUSrcB, ImmSrc, RegSrc  out  2 each  mux selects.
- ALUControl  out  ALUCTRL_W  ALU operation.
- FlagW  out  2  [1]=update NZ, [0]=update CV.
- Illegal  out  1  one-cycle pulse in DECODE for an unimplemented instruction.
- State  out  4  current state, for debug.

## Operation
- States: FETCH(0), DECODE(1), MEMADR(2), MEMREAD(3), MEMWB(4), MEMWRITE(5), EXECR(6), EXECI(7), ALUWB(8), BRANCH(9).
- State transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR if Op=01, →BRANCH if Op=10, →EXECI if Op=00 and I=1, →EXECR if Op=00 and I=0.
  - DECODE→FETCH if the instruction is illegal.
  - MEMADR→MEMREAD if L=1, else →MEMWRITE.
  - MEMREAD→MEMWB. MEMWB, MEMWRITE and BRANCH→FETCH.
  - EXECR and EXECI→ALUWB, except CMP/TST go directly to FETCH.
  - ALUWB→FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=CondEx.
  - MEMWRITE: AdrSrc=1, MemW=CondEx.
  - EXECR: ALUSrcB=00, ALU decode active.
  - EXECI: ALUSrcB=01, ALU decode active.
  - ALUWB: RegW=CondEx.
  - BRANCH: ALUSrcB=01, add, ResultSrc=10, PCWrite=CondEx.
- PC write-back: in MEMWB or ALUWB with Rd=1111, PCWrite=RegW.
- ALU decode by cmd (EXECR/EXECI only):
  - 0100 ADD→000, 0010 SUB→001, 0000 AND→010, 1100 ORR→011.
  - EXT_OPS=1 only: 0001 EOR→100, 1101 MOV→101, 1010 CMP→001, 1000 TST→010.
  - Any other cmd, or an extended cmd when EXT_OPS=0: Illegal=1.
  - Outside the ALU-decode states, ALUControl=0.
- FlagW (EXECR/EXECI only, gated by CondEx):
  - [1]=S, forced to 1 for CMP/TST.
  - [0]=[1] & (ADD|SUB|CMP).
- Source decode from Op, held constant in every state:
  - ImmSrc: 00 for DP, 01 for memory, 10 for branch.
  - RegSrc[0]=1 for branch. RegSrc[1]=1 for STR.
- Op=11 is illegal.
- Illegal: asserted in DECODE only, and no write enable is asserted for that instruction.

## Timing
- Outputs are combinational from State, plus the registered Op/Funct/Rd/CondEx fields. There are no registered outputs.
- Cycles per instruction, counting FETCH:
  - B: 3.
  - STR: 4. LDR: 5.
  - DP: 4. CMP/TST: 3.
  - Illegal: 2.
- Reset:
  - While reset=0, the next state is FETCH.
  - While reset=0, all write enables (PCWrite, IRWrite, RegW, MemW, FlagW) are forced to 0 and Illegal=0.
  - On the first cycle after release, State=0 with IRWrite=1 and PCWrite=1.
- Reset asserted mid-instruction (e.g. in MEMWRITE): MemW drops in that same cycle, and the state is FETCH on the next edge.
- CondEx=0 suppresses RegW, MemW, FlagW and the branch/Rd=15 PCWrite, but the FETCH PCWrite is unaffected. The state sequence is unchanged.
- State never holds two consecutive cycles except FETCH under reset. No unreachable encoding persists: any state in 10–15 goes to FETCH next cycle.

## Test plan
- Reset held for 3 cycles, then released: State=0 throughout. All write enables are 0 while reset=0, then IRWrite=PCWrite=1 in the first cycle after release.
- ADD with I=0, S=1 and CondEx=1:
  - State sequence 0,1,6,8,0.
  - In EXECR: ALUControl=000 and FlagW=11.
  - In ALUWB: RegW=1.
- LDR (Op=01, L=1) with Rd=15: sequence 0,1,2,3,4,0. In MEMWB, RegW=PCWrite=1 and ResultSrc=01.
- CMP (cmd=1010, S=0) with EXT_OPS=1: sequence 0,1,6,0. In EXECR, ALUControl=001 and FlagW=11, and RegW never asserts.
- Two failing cases, each giving sequence 0,1,0 with Illegal=1 in DECODE and no writes:
  - EOR with EXT_OPS=0.
  - Op=11.
- B with CondEx=0: sequence 0,1,9,0 with PCWrite=0 in BRANCH. The same B with CondEx=1 gives PCWrite=1 in BRANCH.

Source files
------------

// File: rtl/multicycle_decoder.sv
// multicycle_decoder: Moore control FSM for a multicycle ARM datapath.
// Sequences fetch, decode, execute, memory and write-back over one shared
// ALU and memory port, and decodes the data-processing command into an ALU
// operation and flag-write enables. Op/Funct/Rd/CondEx come from registered
// sources (instruction register / condition flops) and are used directly.
module multicycle_decoder #(
  parameter bit EXT_OPS   = 1'b1,  // 1: EOR/MOV/CMP/TST also decode as legal
  parameter int ALUCTRL_W = 3      // >=3 with EXT_OPS, >=2 without
) (
  input  logic                 clk,
  input  logic                 reset,      // synchronous, active-low
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 CondEx,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic                 Illegal,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  state_e state_q;
  state_e state_d;

  // Instruction field aliases: Funct = {I, cmd[3:0], S/L}
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       rd_is_pc;

  assign i_bit    = Funct[5];
  assign cmd      = Funct[4:1];
  assign s_bit    = Funct[0];
  assign rd_is_pc = (Rd == 4'hF);

  // ALU command decode; anything not matched leaves dp_legal low
  logic [2:0] alu_code;
  logic       dp_legal;
  logic       is_cmp_tst;
  logic       is_arith;   // ADD, SUB or CMP: these also update C and V

  always_comb begin
    alu_code   = ALU_ADD;
    dp_legal   = 1'b0;
    is_cmp_tst = 1'b0;
    is_arith   = 1'b0;
    case (cmd)
      4'b0100: begin alu_code = ALU_ADD; dp_legal = 1'b1; is_arith = 1'b1; end
      4'b0010: begin alu_code = ALU_SUB; dp_legal = 1'b1; is_arith = 1'b1; end
      4'b0000: begin alu_code = ALU_AND; dp_legal = 1'b1; end
      4'b1100: begin alu_code = ALU_ORR; dp_legal = 1'b1; end
      4'b0001: begin
        if (EXT_OPS) begin alu_code = ALU_EOR; dp_legal = 1'b1; end
      end
      4'b1101: begin
        if (EXT_OPS) begin alu_code = ALU_MOV; dp_legal = 1'b1; end
      end
      4'b1010: begin
        if (EXT_OPS) begin
          alu_code = ALU_SUB; dp_legal = 1'b1; is_cmp_tst = 1'b1; is_arith = 1'b1;
        end
      end
      4'b1000: begin
        if (EXT_OPS) begin alu_code = ALU_AND; dp_legal = 1'b1; is_cmp_tst = 1'b1; end
      end
      default: ;
    endcase
  end

  // Op=11 is never implemented; Op=00 is only legal for a decodable cmd
  logic instr_illegal;
  assign instr_illegal = (Op == 2'b11) || ((Op == 2'b00) && !dp_legal);

  // Flag-write enables, meaningful only in the execute states
  logic flag_nz;
  logic flag_cv;
  assign flag_nz = (s_bit | is_cmp_tst) & CondEx;
  assign flag_cv = flag_nz & is_arith;

  // Next-state logic; unreachable encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (instr_illegal) begin
          state_d = S_FETCH;
        end else begin
          case (Op)
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:   state_d = is_cmp_tst ? S_FETCH : S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs per state; write enables and Illegal are killed during reset
  logic [2:0] alu_sel;

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcB   = 2'b00;
    alu_sel   = ALU_ADD;
    FlagW     = 2'b00;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        alu_sel   = ALU_ADD;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Illegal   = instr_illegal;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        alu_sel = ALU_ADD;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = CondEx;
        PCWrite   = CondEx & rd_is_pc;   // LDR into R15 also loads the PC
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = CondEx;
      end
      S_EXECR: begin
        ALUSrcB = 2'b00;
        alu_sel = alu_code;
        FlagW   = {flag_nz, flag_cv};
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_sel = alu_code;
        FlagW   = {flag_nz, flag_cv};
      end
      S_ALUWB: begin
        RegW    = CondEx;
        PCWrite = CondEx & rd_is_pc;     // DP result into R15 is a jump
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        alu_sel   = ALU_ADD;
        PCWrite   = CondEx;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      FlagW   = 2'b00;
      Illegal = 1'b0;
    end
  end

  // Source selects depend only on the instruction class, in every state
  assign ImmSrc = (Op == 2'b01) ? 2'b01 :
                  (Op == 2'b10) ? 2'b10 : 2'b00;
  assign RegSrc = {(Op == 2'b01) && !s_bit, (Op == 2'b10)};

  assign ALUControl = ALUCTRL_W'(alu_sel);
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_decoder.sv
// tb_multicycle_decoder: two lanes (EXT_OPS=1 and EXT_OPS=0) each run a
// directed prologue then random instructions. A behavioural model derives the
// expected state path of each instruction from its class, and the expected
// outputs from the state and fields; one negedge process compares every cycle.
module tb_multicycle_decoder;

  typedef struct packed {
    logic [3:0] state;
    logic       pcw;
    logic       irw;
    logic       regw;
    logic       memw;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] resultsrc;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [2:0] aluctrl;
    logic [1:0] flagw;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       ce;
  } instr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] op     [2];
  logic [5:0] funct  [2];
  logic [3:0] rd     [2];
  logic       condex [2];

  // lane 0 outputs (EXT_OPS=1)
  logic       pcw_e, irw_e, regw_e, memw_e, adr_e, srca_e, ill_e;
  logic [1:0] res_e, srcb_e, imm_e, regsrc_e, flg_e;
  logic [2:0] alu_e;
  logic [3:0] st_e;
  // lane 1 outputs (EXT_OPS=0, 2-bit ALUControl)
  logic       pcw_b, irw_b, regw_b, memw_b, adr_b, srca_b, ill_b;
  logic [1:0] res_b, srcb_b, imm_b, regsrc_b, flg_b;
  logic [1:0] alu_b;
  logic [3:0] st_b;

  multicycle_decoder #(.EXT_OPS(1'b1), .ALUCTRL_W(3)) u_ext (
    .clk(clk), .reset(rst_n), .Op(op[0]), .Funct(funct[0]), .Rd(rd[0]), .CondEx(condex[0]),
    .PCWrite(pcw_e), .IRWrite(irw_e), .RegW(regw_e), .MemW(memw_e),
    .AdrSrc(adr_e), .ALUSrcA(srca_e), .ResultSrc(res_e), .ALUSrcB(srcb_e),
    .ImmSrc(imm_e), .RegSrc(regsrc_e), .ALUControl(alu_e), .FlagW(flg_e),
    .Illegal(ill_e), .State(st_e)
  );

  multicycle_decoder #(.EXT_OPS(1'b0), .ALUCTRL_W(2)) u_base (
    .clk(clk), .reset(rst_n), .Op(op[1]), .Funct(funct[1]), .Rd(rd[1]), .CondEx(condex[1]),
    .PCWrite(pcw_b), .IRWrite(irw_b), .RegW(regw_b), .MemW(memw_b),
    .AdrSrc(adr_b), .ALUSrcA(srca_b), .ResultSrc(res_b), .ALUSrcB(srcb_b),
    .ImmSrc(imm_b), .RegSrc(regsrc_b), .ALUControl(alu_b), .FlagW(flg_b),
    .Illegal(ill_b), .State(st_b)
  );

  outs_t got_e, got_b;
  assign got_e = {st_e, pcw_e, irw_e, regw_e, memw_e, adr_e, srca_e, res_e, srcb_e,
                  imm_e, regsrc_e, alu_e, flg_e, ill_e};
  assign got_b = {st_b, pcw_b, irw_b, regw_b, memw_b, adr_b, srca_b, res_b, srcb_b,
                  imm_b, regsrc_b, {1'b0, alu_b}, flg_b, ill_b};

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  // ALU code for a DP command; a negative value marks an unimplemented command
  function automatic int alu_code(input bit ext, input logic [3:0] c);
    case (c)
      4'h4: return 0;               // ADD
      4'h2: return 1;               // SUB
      4'h0: return 2;               // AND
      4'hC: return 3;               // ORR
      4'h1: return ext ? 4 : -1;    // EOR
      4'hD: return ext ? 5 : -1;    // MOV
      4'hA: return ext ? 1 : -1;    // CMP
      4'h8: return ext ? 2 : -1;    // TST
      default: return -1;
    endcase
  endfunction

  // Sequence of states an instruction walks through, starting at FETCH
  function automatic void build_path(input bit ext, input logic [1:0] o, input logic [5:0] f,
                                     output logic [5:0][3:0] seq, output int n);
    logic [3:0] c;
    c = f[4:1];
    seq = '0;
    seq[0] = 4'd0;
    seq[1] = 4'd1;
    if (o == 2'b11 || (o == 2'b00 && alu_code(ext, c) < 0)) begin
      n = 2;
    end else if (o == 2'b10) begin
      seq[2] = 4'd9; n = 3;
    end else if (o == 2'b01) begin
      seq[2] = 4'd2;
      if (f[0]) begin seq[3] = 4'd3; seq[4] = 4'd4; n = 5; end
      else      begin seq[3] = 4'd5; n = 4; end
    end else begin
      seq[2] = f[5] ? 4'd7 : 4'd6;
      if (ext && (c == 4'hA || c == 4'h8)) n = 3;
      else begin seq[3] = 4'd8; n = 4; end
    end
  endfunction

  function automatic outs_t exp_outs(input bit ext, input int s, input logic [1:0] o,
                                     input logic [5:0] f, input logic [3:0] r,
                                     input logic ce, input logic rn);
    outs_t e;
    int    code;
    bit    exec, wb, ct, nz;
    e    = '0;
    code = alu_code(ext, f[4:1]);
    exec = (s == 6 || s == 7);
    wb   = (s == 4 || s == 8);
    ct   = ext && (f[4:1] == 4'hA || f[4:1] == 4'h8);
    e.state     = 4'(s);
    e.irw       = (s == 0);
    e.pcw       = (s == 0) || (s == 9 && ce) || (wb && ce && r == 4'hF);
    e.regw      = wb && ce;
    e.memw      = (s == 5) && ce;
    e.adrsrc    = (s == 3 || s == 5);
    e.alusrca   = (s <= 1);
    e.alusrcb   = (s <= 1) ? 2'b10 : (s == 2 || s == 7 || s == 9) ? 2'b01 : 2'b00;
    e.resultsrc = (s <= 1 || s == 9) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
    e.immsrc    = (o == 2'b11) ? 2'b00 : o;
    e.regsrc    = {o == 2'b01 && !f[0], o == 2'b10};
    if (exec) begin
      e.aluctrl = 3'(code);
      nz        = (f[0] || ct) && ce;
      e.flagw   = {nz, nz && (code == 0 || code == 1)};
    end
    e.illegal = (s == 1) && (o == 2'b11 || (o == 2'b00 && code < 0));
    if (!rn) begin
      e.pcw = 0; e.irw = 0; e.regw = 0; e.memw = 0; e.flagw = 2'b00; e.illegal = 0;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  logic [5:0][3:0] q_seq [2];
  int     q_n   [2];
  int     q_pos [2];
  int     cur   [2];
  int     dir_idx [2];
  instr_t dir0 [7];
  instr_t dir1 [2];
  bit     chk_on = 0;
  bit     obs_on = 0;
  int     obs_idx = 0;
  outs_t  rec0 [20];
  outs_t  rec1 [20];
  int     pin_st0 [20] = '{0,1,6,8, 0,1,2,3,4, 0,1,6, 0,1, 0,1,9, 0,1,9};
  int     pin_st1 [6]  = '{0,1, 0,1,7,8};

  task automatic next_instr(input int l);
    instr_t in;
    int     r;
    if (l == 0 && dir_idx[0] < 7) begin
      in = dir0[dir_idx[0]]; dir_idx[0]++;
    end else if (l == 1 && dir_idx[1] < 2) begin
      in = dir1[dir_idx[1]]; dir_idx[1]++;
    end else begin
      r        = int'($urandom_range(0, 9));
      in.op    = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      in.funct = 6'($urandom_range(0, 63));
      in.rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      in.ce    = ($urandom_range(0, 3) != 0);
    end
    op[l] = in.op; funct[l] = in.funct; rd[l] = in.rd; condex[l] = in.ce;
    build_path(l == 0, in.op, in.funct, q_seq[l], q_n[l]);
    q_pos[l] = 0;
  endtask

  task automatic pin(input string nm, input int g, input int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL pin %s: got=%0d want=%0d", nm, g, e);
    end
  endtask

  // Per-cycle comparison of both lanes against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int l = 0; l < 2; l++) begin
        outs_t g, e;
        g = (l == 0) ? got_e : got_b;
        e = exp_outs(l == 0, cur[l], op[l], funct[l], rd[l], condex[l], rst_n);
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL lane%0d outs t=%0t state got=%0d want=%0d vec got=%h want=%h",
                   l, $time, g.state, e.state, g, e);
        end
      end
      if (obs_on && obs_idx < 20) begin
        rec0[obs_idx] = got_e;
        rec1[obs_idx] = got_b;
        obs_idx++;
      end
    end
  end

  initial begin
    logic rst_now, rst_prev;
    int   rst_hold;
    bit   armed, released;
    // lane 0 directed: ADD S=1, LDR R15, CMP, Op=11, B ce=0, B ce=1, STR
    dir0[0] = '{2'b00, 6'b0_0100_1, 4'd2,  1'b1};
    dir0[1] = '{2'b01, 6'b0_1100_1, 4'd15, 1'b1};
    dir0[2] = '{2'b00, 6'b0_1010_0, 4'd0,  1'b1};
    dir0[3] = '{2'b11, 6'b0_0000_0, 4'd1,  1'b1};
    dir0[4] = '{2'b10, 6'b10_0000,  4'd0,  1'b0};
    dir0[5] = '{2'b10, 6'b10_0000,  4'd0,  1'b1};
    dir0[6] = '{2'b01, 6'b0_1100_0, 4'd3,  1'b1};
    // lane 1 directed: EOR (illegal without ext ops), ADD imm into R15
    dir1[0] = '{2'b00, 6'b0_0001_1, 4'd4,  1'b1};
    dir1[1] = '{2'b00, 6'b1_0100_0, 4'd15, 1'b1};
    for (int l = 0; l < 2; l++) begin
      op[l] = 2'b00; funct[l] = 6'd0; rd[l] = 4'd0; condex[l] = 1'b0;
      q_n[l] = 0; q_pos[l] = 0; cur[l] = 0; dir_idx[l] = 0;
    end
    rst_n = 1'b0; rst_prev = 1'b0; rst_hold = 3; armed = 1; released = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst_now = 1'b1;
      if (rst_hold > 0) begin
        rst_now = 1'b0; rst_hold--;
      end else if (cyc > 300 && $urandom_range(0, 63) == 0) begin
        rst_now = 1'b0; rst_hold = int'($urandom_range(0, 2));
      end
      for (int l = 0; l < 2; l++) begin
        if (!rst_prev) q_pos[l] = q_n[l];
        if (!rst_prev && !rst_now) begin
          cur[l] = 0;
        end else begin
          if (q_pos[l] >= q_n[l]) next_instr(l);
          cur[l] = int'(q_seq[l][q_pos[l]]);
          q_pos[l]++;
        end
      end
      // reset dropped while the STR sits in MEMWRITE
      if (armed && rst_now && cur[0] == 5) begin
        rst_now = 1'b0; rst_hold = 1; armed = 0;
      end
      if (rst_now && !released) begin
        released = 1; obs_on = 1;
      end
      rst_n    = rst_now;
      rst_prev = rst_now;
      chk_on   = 1;
    end
    @(negedge clk); #1;
    chk_on = 0;
    // literal expectations for the directed prologue
    pin("obs_count", obs_idx, 20);
    for (int i = 0; i < 20; i++) pin($sformatf("lane0_state[%0d]", i), int'(rec0[i].state), pin_st0[i]);
    for (int i = 0; i < 6; i++)  pin($sformatf("lane1_state[%0d]", i), int'(rec1[i].state), pin_st1[i]);
    pin("release_irw",     int'(rec0[0].irw), 1);
    pin("release_pcw",     int'(rec0[0].pcw), 1);
    pin("add_alu",         int'(rec0[2].aluctrl), 0);
    pin("add_flagw",       int'(rec0[2].flagw), 3);
    pin("add_regw",        int'(rec0[3].regw), 1);
    pin("ldr_regw",        int'(rec0[8].regw), 1);
    pin("ldr_pcw",         int'(rec0[8].pcw), 1);
    pin("ldr_resultsrc",   int'(rec0[8].resultsrc), 1);
    pin("cmp_alu",         int'(rec0[11].aluctrl), 1);
    pin("cmp_flagw",       int'(rec0[11].flagw), 3);
    pin("op11_illegal",    int'(rec0[13].illegal), 1);
    pin("b_nocond_pcw",    int'(rec0[16].pcw), 0);
    pin("b_cond_pcw",      int'(rec0[19].pcw), 1);
    pin("eor_base_illegal", int'(rec1[1].illegal), 1);
    pin("addi_r15_pcw",    int'(rec1[5].pcw), 1);
    pin("str_mid_reset",   int'(armed), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
